// File: rtl/pwm_capture_if.sv
// PWM capture bus: the measured PWM/direction inputs and the measurement results.
// The master side drives the PWM pair and consumes results; the slave side is the capture block.
interface pwm_capture_if #(
    parameter int unsigned CNT_W = 16
);
    logic             pwm_in;
    logic             dir_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             dir_out;
    logic             meas_valid;
    logic             timeout;

    modport master (
        output pwm_in,
        output dir_in,
        input  high_cnt,
        input  period_cnt,
        input  dir_out,
        input  meas_valid,
        input  timeout
    );

    modport slave (
        input  pwm_in,
        input  dir_in,
        output high_cnt,
        output period_cnt,
        output dir_out,
        output meas_valid,
        output timeout
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM input, rising edge to
// rising edge, and samples the direction input at the closing edge. Reports a stuck level
// when no edge is seen for TIMEOUT cycles.
// Optional glitch filter on the synchronised PWM input: define PWM_CAP_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned TIMEOUT  = 65535,
    parameter int unsigned FILT_LEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    pwm_capture_if.slave  bus
);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e           state_q, state_d;
    logic [1:0]       pwm_sync_q, dir_sync_q;
    logic             pwm_s, dir_s, pwm_f;
    logic             pwm_q;
    logic             rise, fall;
    logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic             tmo_hit;
    logic [CNT_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0] hi_inc, lo_inc;
    logic [CNT_W:0]   period_sum;
    logic [CNT_W-1:0] period_clamp;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d, period_cnt_q, period_cnt_d;
    logic             dir_out_q, dir_out_d;
    logic             valid_q, valid_d;
    logic             tmo_flag_q, tmo_flag_d;

    // Two-flop synchronisers for the asynchronous inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_sync_q <= '0;
            dir_sync_q <= '0;
        end else begin
            pwm_sync_q <= {pwm_sync_q[0], bus.pwm_in};
            dir_sync_q <= {dir_sync_q[0], bus.dir_in};
        end
    end

    assign pwm_s = pwm_sync_q[1];
    assign dir_s = dir_sync_q[1];

`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam int unsigned FiltW = $clog2(FILT_LEN + 1);

    logic             filt_q, filt_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;

    // Filtered level follows pwm_s only after FILT_LEN consecutive differing samples
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (pwm_s != filt_q) begin
            if (filt_cnt_q == FiltW'(FILT_LEN - 1)) begin
                filt_d = pwm_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // Glitch filter state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign pwm_f = filt_q;
`else
    assign pwm_f = pwm_s;
`endif

    assign rise = pwm_f & ~pwm_q;
    assign fall = ~pwm_f & pwm_q;

    // Edge-free cycle counter; holds at the hit value so it cannot re-fire while idle
    always_comb begin
        tmo_hit = (tmo_cnt_q == TmoW'(TIMEOUT - 1));
        if (rise || fall) begin
            tmo_cnt_d = '0;
        end else if (tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Saturating accumulators and the clamped period sum
    always_comb begin
        hi_inc       = (hi_q == CntMax) ? hi_q : hi_q + 1'b1;
        lo_inc       = (lo_q == CntMax) ? lo_q : lo_q + 1'b1;
        period_sum   = {1'b0, hi_q} + {1'b0, lo_q};
        period_clamp = period_sum[CNT_W] ? CntMax : period_sum[CNT_W-1:0];
    end

    // Measurement FSM: next state, accumulators and result latching
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        dir_out_d    = dir_out_q;
        valid_d      = 1'b0;
        tmo_flag_d   = tmo_flag_q;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d    = StHigh;
                    hi_d       = CNT_W'(1);
                    lo_d       = '0;
                    tmo_flag_d = 1'b0;
                end
            end
            StHigh: begin
                if (fall) begin
                    state_d = StLow;
                    lo_d    = CNT_W'(1);
                end else if (tmo_hit) begin
                    high_cnt_d   = pwm_f ? CntMax : '0;
                    period_cnt_d = '0;
                    dir_out_d    = dir_s;
                    valid_d      = 1'b1;
                    tmo_flag_d   = 1'b1;
                    state_d      = StIdle;
                end else begin
                    hi_d = hi_inc;
                end
            end
            StLow: begin
                if (rise) begin
                    high_cnt_d   = hi_q;
                    period_cnt_d = period_clamp;
                    dir_out_d    = dir_s;
                    valid_d      = 1'b1;
                    hi_d         = CNT_W'(1);
                    lo_d         = '0;
                    state_d      = StHigh;
                end else if (tmo_hit) begin
                    high_cnt_d   = pwm_f ? CntMax : '0;
                    period_cnt_d = '0;
                    dir_out_d    = dir_s;
                    valid_d      = 1'b1;
                    tmo_flag_d   = 1'b1;
                    state_d      = StIdle;
                end else begin
                    lo_d = lo_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, accumulators and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            pwm_q        <= 1'b0;
            tmo_cnt_q    <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            dir_out_q    <= 1'b0;
            valid_q      <= 1'b0;
            tmo_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwm_q        <= pwm_f;
            tmo_cnt_q    <= tmo_cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            dir_out_q    <= dir_out_d;
            valid_q      <= valid_d;
            tmo_flag_q   <= tmo_flag_d;
        end
    end

    assign bus.high_cnt   = high_cnt_q;
    assign bus.period_cnt = period_cnt_q;
    assign bus.dir_out    = dir_out_q;
    assign bus.meas_valid = valid_q;
    // The rising edge that ends a stuck-level report clears the flag in its detection cycle
    assign bus.timeout    = tmo_flag_q & ~rise;
endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: directed and random PWM waveforms, checked every cycle against
// a reference model that derives measurements from the waveform's edge positions.
module tb_pwm_capture;
    localparam int unsigned CW  = 8;
    localparam int unsigned TMO = 400;
    localparam int unsigned FL  = 4;
    localparam int SatMax = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pwm_capture_if #(.CNT_W(CW)) bus ();

    pwm_capture #(
        .CNT_W    (CW),
        .TIMEOUT  (TMO),
        .FILT_LEN (FL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    bit wq[$];
    bit dq[$];
    int exp_valid[], exp_hi[], exp_per[], exp_dir[], exp_to[];
    int ev_valid[], ev_hi[], ev_per[], ev_dir[], ev_set[], ev_clr[];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic add_phase(input bit lvl, input int len, input bit d);
        repeat (len) begin
            wq.push_back(lvl);
            dq.push_back(d);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic post(input int t, input int hi, input int per, input int d, input int set);
        if (t < wq.size()) begin
            ev_valid[t] = 1;
            ev_hi[t]    = hi;
            ev_per[t]   = per;
            ev_dir[t]   = d;
            ev_set[t]   = set;
        end
    endtask

    // Reference model: find edges of the effective level sequence, derive one measurement per
    // rise-to-rise period, a stuck-level report when the gap to the next edge exceeds TMO, and
    // place each result 2 sample slots after the edge that produced it.
    task automatic build_model();
        int n = wq.size();
        bit x[];
        bit g[];
        int state = 0;  // 0 idle, 1 high, 2 low
        int last_e = 0, start = 0, fall_i = 0;
        bit prev = 1'b0;
        int c_hi = 0, c_per = 0, c_dir = 0, c_to = 0;
        x = new[n];
        g = new[n];
        for (int m = 0; m < n; m++) begin
`ifdef PWM_CAP_GLITCH_FILTER_EN
            bit all_eq = 1'b1;
            for (int j = 0; j < int'(FL); j++) begin
                bit v = (m - j < 0) ? 1'b0 : wq[m - j];
                if (v != wq[m]) all_eq = 1'b0;
            end
            g[m] = all_eq ? wq[m] : ((m == 0) ? 1'b0 : g[m - 1]);
            x[m] = (m == 0) ? 1'b0 : g[m - 1];
`else
            g[m] = wq[m];
            x[m] = g[m];
`endif
        end
        exp_valid = new[n]; exp_hi = new[n]; exp_per = new[n]; exp_dir = new[n];
        exp_to = new[n];
        ev_valid = new[n]; ev_hi = new[n]; ev_per = new[n]; ev_dir = new[n];
        ev_set = new[n]; ev_clr = new[n];
        for (int i = 0; i <= n; i++) begin
            bit lvl = (i < n) ? x[i] : prev;
            int e = (i < n) ? i : n + int'(TMO) + 10;
            if (i < n && lvl == prev) continue;
            if (state != 0 && e - last_e > int'(TMO)) begin
                int di = last_e + int'(TMO);
                post(di + 2, (state == 1) ? SatMax : 0, 0, (di < n) ? int'(dq[di]) : 0, 1);
                state = 0;
            end
            if (i == n) break;
            if (lvl) begin
                if (state == 0) begin
                    state = 1;
                    start = i;
                    if (i + 1 < n) ev_clr[i + 1] = 1;
                end else if (state == 2) begin
                    int hi = imin(fall_i - start, SatMax);
                    int lo = imin(i - fall_i, SatMax);
                    post(i + 2, hi, imin(hi + lo, SatMax), int'(dq[i]), 0);
                    start = i;
                    state = 1;
                end
            end else if (state == 1) begin
                fall_i = i;
                state  = 2;
            end
            prev   = lvl;
            last_e = i;
        end
        for (int t = 0; t < n; t++) begin
            if (ev_clr[t] != 0) c_to = 0;
            if (ev_valid[t] != 0) begin
                c_hi = ev_hi[t];
                c_per = ev_per[t];
                c_dir = ev_dir[t];
                if (ev_set[t] != 0) c_to = 1;
            end
            exp_valid[t] = ev_valid[t];
            exp_hi[t]    = c_hi;
            exp_per[t]   = c_per;
            exp_dir[t]   = c_dir;
            exp_to[t]    = c_to;
        end
    endtask

    task automatic check_slot(input string name, input int t);
        chk($sformatf("%s[%0d].meas_valid", name, t), 32'(bus.meas_valid), exp_valid[t]);
        chk($sformatf("%s[%0d].high_cnt", name, t), 32'(bus.high_cnt), exp_hi[t]);
        chk($sformatf("%s[%0d].period_cnt", name, t), 32'(bus.period_cnt), exp_per[t]);
        chk($sformatf("%s[%0d].dir_out", name, t), 32'(bus.dir_out), exp_dir[t]);
        chk($sformatf("%s[%0d].timeout", name, t), 32'(bus.timeout), exp_to[t]);
    endtask

    // Reset (pwm_in left as is, so a level held across reset is seen afresh), then play the
    // queued waveform one sample per cycle and compare every cycle.
    task automatic run_seg(input string name);
        int n;
        build_model();
        n = wq.size();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({name, ".rst.meas_valid"}, 32'(bus.meas_valid), 0);
        chk({name, ".rst.high_cnt"}, 32'(bus.high_cnt), 0);
        chk({name, ".rst.period_cnt"}, 32'(bus.period_cnt), 0);
        chk({name, ".rst.dir_out"}, 32'(bus.dir_out), 0);
        chk({name, ".rst.timeout"}, 32'(bus.timeout), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(negedge clk);
                check_slot(name, i - 1);
            end
            bus.pwm_in = wq[i];
            bus.dir_in = dq[i];
        end
        @(negedge clk);
        check_slot(name, n - 1);
        wq.delete();
        dq.delete();
    endtask

    initial begin
        bus.pwm_in = 1'b0;
        bus.dir_in = 1'b0;

        // 30/70 periods, dir=1
        add_phase(1'b0, 5, 1'b1);
        repeat (5) begin
            add_phase(1'b1, 30, 1'b1);
            add_phase(1'b0, 70, 1'b1);
        end
        add_phase(1'b1, 5, 1'b1);
        run_seg("basic");

        // Duty sweep at period 200, then stuck high and stuck low
        add_phase(1'b0, 5, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            repeat (2) begin
                add_phase(1'b1, 20 * k, k[0]);
                add_phase(1'b0, 200 - 20 * k, k[0]);
            end
        end
        add_phase(1'b1, 600, 1'b1);
        add_phase(1'b0, 20, 1'b0);
        add_phase(1'b1, 20, 1'b0);
        add_phase(1'b0, 600, 1'b0);
        run_seg("sweep");

        // Long high phase saturates the counters
        add_phase(1'b0, 3, 1'b0);
        repeat (3) begin
            add_phase(1'b1, 300, 1'b0);
            add_phase(1'b0, 10, 1'b1);
        end
        add_phase(1'b1, 4, 1'b1);
        run_seg("sat");

        // Stuck high after a period, recovery, then normal periods
        add_phase(1'b1, 30, 1'b1);
        add_phase(1'b0, 70, 1'b1);
        add_phase(1'b1, 30, 1'b0);
        add_phase(1'b0, 70, 1'b0);
        add_phase(1'b1, 500, 1'b1);
        add_phase(1'b0, 20, 1'b0);
        repeat (3) begin
            add_phase(1'b1, 30, 1'b1);
            add_phase(1'b0, 70, 1'b0);
        end
        add_phase(1'b1, 5, 1'b0);
        run_seg("stuck");

        // Leave the input high, reset mid-high, resume 50/50
        add_phase(1'b0, 4, 1'b0);
        add_phase(1'b1, 50, 1'b0);
        add_phase(1'b0, 50, 1'b0);
        add_phase(1'b1, 25, 1'b0);
        run_seg("prerst");
        add_phase(1'b1, 25, 1'b1);
        repeat (3) begin
            add_phase(1'b0, 50, 1'b1);
            add_phase(1'b1, 50, 1'b1);
        end
        run_seg("postrst");

        // Short low glitch inside the high phase
        add_phase(1'b0, 6, 1'b0);
        repeat (3) begin
            add_phase(1'b1, 19, 1'b1);
            add_phase(1'b0, 2, 1'b1);
            add_phase(1'b1, 19, 1'b1);
            add_phase(1'b0, 60, 1'b1);
        end
        add_phase(1'b1, 6, 1'b0);
        run_seg("glitch");

        // Random phases, including 1-cycle pulses and occasional stuck levels
        for (int s = 0; s < 3; s++) begin
            bit lvl = 1'b0;
            for (int p = 0; p < 40; p++) begin
                int len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO - 2, TMO + 40))
                                                      : int'($urandom_range(1, 80));
                add_phase(lvl, len, 1'($urandom));
                lvl = ~lvl;
            end
            run_seg($sformatf("rand%0d", s));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
